// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 512-bit blocks with
// FIPS 180-4 padding. Define SHA256_PADDER_PROTO_CHK_EN to add the sticky err_o protocol flag.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  data_i,
  input  logic         data_vld_i,
  input  logic         data_last_i,
  input  logic [2:0]   data_nbytes_i,
  output logic         data_rdy_o,
  output logic [511:0] blk_o,
  output logic         blk_vld_o,
  input  logic         blk_rdy_i,
  output logic         blk_first_o,
  output logic         blk_last_o
`ifdef SHA256_PADDER_PROTO_CHK_EN
  ,
  output logic         err_o
`endif
);

  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_e;

  state_e             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               mark_q, mark_d;   // 0x80 marker still owed (last word was full)
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;   // padding continues in the block after this one

  logic               acc;
  logic [2:0]         nb;
  logic [31:0]        keep_mask;
  logic [31:0]        marker;
  logic [8:0]         wsel;

  assign acc  = data_vld_i && (state_q == FILL);
  assign nb   = (data_nbytes_i > 3'd4) ? 3'd4 : data_nbytes_i;
  // Word i occupies bits [32*(15-i) +: 32]; 15-i is the bitwise inverse of a 4-bit index.
  assign wsel = {~widx_q, 5'b00000};

  always_comb begin
    keep_mask = 32'hFFFF_FFFF;
    marker    = 32'h0000_0000;
    case (nb)
      3'd0:    begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
      3'd1:    begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
      3'd2:    begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
      3'd3:    begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
      default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h0000_0000; end
    endcase
  end

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    mark_d  = mark_q;
    first_d = first_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          widx_d = widx_q + 4'd1;
          if (data_last_i) begin
            blk_d[wsel +: 32] = (data_i & keep_mask) | marker;
            cnt_d  = cnt_q + LEN_W'({nb, 3'b000});
            mark_d = (nb == 3'd4);
            if (widx_q == 4'd15) begin
              state_d = EMIT;
              pend_d  = 1'b1;
              last_d  = 1'b0;
            end else if (nb != 3'd4 && widx_q == 4'd13) begin
              state_d = LEN;
            end else begin
              state_d = PAD;
            end
          end else begin
            blk_d[wsel +: 32] = data_i;
            cnt_d = cnt_q + LEN_W'(32);
            if (widx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end
          end
        end
      end
      PAD: begin
        blk_d[wsel +: 32] = mark_q ? 32'h8000_0000 : 32'h0000_0000;
        mark_d = 1'b0;
        widx_d = widx_q + 4'd1;
        if (widx_q == 4'd13) begin
          state_d = LEN;
        end else if (widx_q == 4'd15) begin
          state_d = EMIT;
          pend_d  = 1'b1;
        end
      end
      LEN: begin
        blk_d[63:0] = 64'(cnt_q);
        last_d  = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_rdy_i) begin
          widx_d  = 4'd0;
          first_d = 1'b0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          if (last_q) begin
            first_d = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end else if (pend_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the block buffer is reset too, since blk_o must read as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
      blk_q   <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      mark_q  <= 1'b0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q <= state_d;
      blk_q   <= blk_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      mark_q  <= mark_d;
      first_q <= first_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign data_rdy_o  = (state_q == FILL);
  assign blk_vld_o   = (state_q == EMIT);
  assign blk_o       = blk_q;
  assign blk_first_o = first_q;
  assign blk_last_o  = last_q;

`ifdef SHA256_PADDER_PROTO_CHK_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (acc && ((data_last_i && data_nbytes_i > 3'd4) ||
                         (!data_last_i && data_nbytes_i != 3'd4))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed padded blocks, tags, latency, backpressure, reset.
module tb_sha256_padder;

  logic         clk;
  logic         rst;
  logic [31:0]  data;
  logic         dvld;
  logic         dlast;
  logic [2:0]   dnb;
  logic         drdy;
  logic [511:0] blk;
  logic         bvld;
  logic         brdy;
  logic         bfirst;
  logic         blast;
`ifdef SHA256_PADDER_PROTO_CHK_EN
  logic         err;
`endif

  sha256_padder #(.LEN_W(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_i        (data),
    .data_vld_i    (dvld),
    .data_last_i   (dlast),
    .data_nbytes_i (dnb),
    .data_rdy_o    (drdy),
    .blk_o         (blk),
    .blk_vld_o     (bvld),
    .blk_rdy_i     (brdy),
    .blk_first_o   (bfirst),
    .blk_last_o    (blast)
`ifdef SHA256_PADDER_PROTO_CHK_EN
    ,
    .err_o         (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] setw(input logic [511:0] b, input int i, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*i -: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] msg_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Called and returns at a negedge; records the cycle in which the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    t = 0;
    data = d; dlast = last; dnb = nb; dvld = 1'b1;
    while (!drdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!drdy) check("send_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    dvld = 1'b0; dlast = 1'b0; dnb = 3'd0;
  endtask

  task automatic send_msg(input int nw, input logic [2:0] last_nb, input logic [31:0] last_d);
    for (int i = 0; i < nw - 1; i++) send_word(msg_word(i), 1'b0, 3'd4);
    send_word(last_d, 1'b1, last_nb);
  endtask

  task automatic wait_vld(input string tag);
    int t;
    t = 0;
    while (!bvld && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_vld"}, bvld, 1);
  endtask

  task automatic get_blk(input string tag, input logic [511:0] eb, input logic ef, input logic el,
                         input int lat, input int hold);
    wait_vld(tag);
    if (lat >= 0) check({tag, "_lat"}, 512'(cyc - acc_cyc), 512'(lat));
    check({tag, "_blk"}, blk, eb);
    check({tag, "_first"}, bfirst, ef);
    check({tag, "_last"}, blast, el);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_blk"}, blk, eb);
      check({tag, "_hold_vld"}, bvld, 1);
      check({tag, "_hold_rdy"}, drdy, 0);
    end
    brdy = 1'b1;
    @(negedge clk);
    brdy = 1'b0;
    check({tag, "_drop"}, bvld, 0);
  endtask

  logic [511:0] e_abc, e_empty, e1, e2;

  initial begin
    rst = 1'b1; data = '0; dvld = 1'b0; dlast = 1'b0; dnb = 3'd0; brdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_vld", bvld, 0);
    check("rst_rdy", drdy, 1);
    check("rst_first", bfirst, 1);
    check("rst_last", blast, 0);
    check("rst_blk", blk, 0);

    // "abc"
    e_abc = setw('0, 0, 32'h6162_6380);
    e_abc = setw(e_abc, 15, 32'h0000_0018);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_blk("abc", e_abc, 1'b1, 1'b1, 15, 0);
    check("abc_first_rearm", bfirst, 1);
    check("abc_rdy_after", drdy, 1);

    // Empty message; data bits must be ignored entirely.
    e_empty = setw('0, 0, 32'h8000_0000);
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    get_blk("empty", e_empty, 1'b1, 1'b1, 15, 0);

    // 56 bytes: marker spills to word 14, length needs a second block.
    e1 = '0;
    for (int i = 0; i < 14; i++) e1 = setw(e1, i, msg_word(i));
    e1 = setw(e1, 14, 32'h8000_0000);
    e2 = setw('0, 15, 32'h0000_01C0);
    send_msg(14, 3'd4, msg_word(13));
    get_blk("m56_b1", e1, 1'b1, 1'b0, -1, 0);
    get_blk("m56_b2", e2, 1'b0, 1'b1, -1, 0);

    // 58 bytes: partial last word at index 14 carries the marker.
    e1 = '0;
    for (int i = 0; i < 14; i++) e1 = setw(e1, i, msg_word(i));
    e1 = setw(e1, 14, 32'hAABB_8000);
    e2 = setw('0, 15, 32'h0000_01D0);
    send_msg(15, 3'd2, 32'hAABB_CCDD);
    get_blk("m58_b1", e1, 1'b1, 1'b0, -1, 0);
    get_blk("m58_b2", e2, 1'b0, 1'b1, -1, 0);

    // 64 bytes with 10 cycles of backpressure on the data block.
    e1 = '0;
    for (int i = 0; i < 16; i++) e1 = setw(e1, i, msg_word(i));
    e2 = setw('0, 0, 32'h8000_0000);
    e2 = setw(e2, 15, 32'h0000_0200);
    send_msg(16, 3'd4, msg_word(15));
    get_blk("m64_b1", e1, 1'b1, 1'b0, 1, 10);
    get_blk("m64_b2", e2, 1'b0, 1'b1, -1, 0);

    // Two back-to-back messages, each must carry first=1.
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_blk("b2b_a", e_abc, 1'b1, 1'b1, 15, 0);
    send_word(32'h1234_5678, 1'b1, 3'd0);
    get_blk("b2b_b", e_empty, 1'b1, 1'b1, 15, 0);

    // Reset in the middle of padding, after a partial fill has already counted bits.
    send_word(32'h1111_1111, 1'b0, 3'd4);
    send_word(32'h2222_2222, 1'b1, 3'd4);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pad_vld", bvld, 0);
    check("rst_pad_rdy", drdy, 1);
    @(negedge clk);
    rst = 1'b0;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_blk("abc_after_pad_rst", e_abc, 1'b1, 1'b1, 15, 0);

    // Reset while a block is being offered: valid must drop without a clock edge.
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_vld("rst_emit");
    #2 rst = 1'b1;
    #1;
    check("rst_emit_vld", bvld, 0);
    check("rst_emit_blk", blk, 0);
    @(negedge clk);
    rst = 1'b0;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    get_blk("abc_after_emit_rst", e_abc, 1'b1, 1'b1, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
